data_parser_pairing: RTL and testbench

//  Parametrised successor to the triad parser. Pairs two consecutive sweep

---
 rtl/data_parser_pairing.sv | 217 +++++++++++++++++++++
 tb/tb_data_parser_pairing.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_parser_pairing.sv
// -----------------------------------------------------------------------------
// data_parser_pairing
//
// Purpose
//   Pairs two consecutive sweep frames that carry the same pulse identifier.
//   The first frame of a pair is stored. The second frame is accepted only if
//   every sensor timestamp advanced by a legal amount, with wrap-around allowed:
//     delta[k] = (ts_new[k] - ts_old[k]) mod 2**TS_W
//     MIN_DIFF < delta[k] < MAX_DIFF
//   An accepted pair is presented downstream as old/new timestamp iterations
//   on a valid/ready handshake. The upstream frame is acknowledged only after
//   that handshake completes, so downstream backpressure reaches upstream.
//   A stored frame expires after STALE_CYCLES clocks. If a CHECK evaluation
//   happens in the same cycle as the expiry, the CHECK evaluation wins.
//
// Ports
//   clk_72MHz               in   system clock
//   reset                   in   synchronous, active-high reset
//   triad_data              in   {ts[N-1],...,ts[0],id}; id in the LSBs
//   triad_data_avl          in   frame valid; held high until acknowledged
//   reset_pulse_identifier  out  acknowledge to upstream (frame consumed)
//   sensor_iterations       out  {old0,new0,old1,new1,...}; sensor 0 at the MSBs
//   sensor_data_avl         out  output valid
//   sensor_data_rdy         in   downstream ready
//
// Optional feature (macro PARSER_STATS_EN)
//   When PARSER_STATS_EN is defined, the block adds three outputs. Each one is
//   a 16-bit saturating counter, cleared by reset:
//     stat_pairs    PARSE entries
//     stat_rejects  illegal id-matches
//     stat_stale    stale expiries
//   When the macro is undefined, these ports and counters are absent.
// -----------------------------------------------------------------------------
module data_parser_pairing #(
  parameter int NUM_SENSORS  = 3,
  parameter int ID_W         = 17,
  parameter int TS_W         = 17,
  parameter int MIN_DIFF     = 7500,
  parameter int MAX_DIFF     = 65535,
  parameter int STALE_CYCLES = 720000
) (
  input  logic                            clk_72MHz,
  input  logic                            reset,
  input  logic [ID_W+NUM_SENSORS*TS_W-1:0] triad_data,
  input  logic                            triad_data_avl,
  output logic                            reset_pulse_identifier,
  output logic [2*NUM_SENSORS*TS_W-1:0]   sensor_iterations,
  output logic                            sensor_data_avl,
  input  logic                            sensor_data_rdy
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]                     stat_pairs,
  output logic [15:0]                     stat_rejects,
  output logic [15:0]                     stat_stale
`endif
);

  localparam int DATA_W = ID_W + NUM_SENSORS * TS_W;
  localparam int OUT_W  = 2 * NUM_SENSORS * TS_W;
  localparam int CNT_W  = $clog2(STALE_CYCLES + 1);

  localparam logic [TS_W-1:0]  MIN_D     = TS_W'(MIN_DIFF);
  localparam logic [TS_W-1:0]  MAX_D     = TS_W'(MAX_DIFF);
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  typedef enum logic [2:0] {
    S_WAIT,
    S_CHECK,
    S_STORE,
    S_PARSE,
    S_OUT,
    S_ACK
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] stored_q;
  logic              stored_vld_q;
  logic [CNT_W-1:0]  stale_cnt_q;
  logic [OUT_W-1:0]  iter_q;
  logic              avl_q;
  logic              ack_q;

  logic [TS_W-1:0]   delta [NUM_SENSORS];
  logic              legal;
  logic              id_match;
  logic              stale_fire;
  logic [OUT_W-1:0]  pair_data;

  assign sensor_iterations      = iter_q;
  assign sensor_data_avl        = avl_q;
  assign reset_pulse_identifier = ack_q;

  // The identifier comparison is qualified by the valid flag rather than by the
  // stored contents. As a result, an all-zero frame is ordinary data.
  assign id_match = stored_vld_q && (triad_data[ID_W-1:0] == stored_q[ID_W-1:0]);

  // Expiry is suppressed while CHECK is evaluating the stored frame.
  // The expiry then happens one cycle later, unless CHECK consumed or replaced the frame.
  assign stale_fire = stored_vld_q && (stale_cnt_q == STALE_MAX) && (state_q != S_CHECK);

  // Wrap-aware deltas come from the natural TS_W-bit modular subtraction.
  // NOTE: every variable driven here gets a value before any conditional update.
  // Without that, a path that leaves it unassigned would infer a latch.
  always_comb begin
    legal = 1'b1;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      delta[k] = triad_data[ID_W+k*TS_W +: TS_W] - stored_q[ID_W+k*TS_W +: TS_W];
      if (!((delta[k] > MIN_D) && (delta[k] < MAX_D))) begin
        legal = 1'b0;
      end
    end
  end

  // Output packing puts sensor 0 at the MSBs: {old0,new0,old1,new1,...}.
  always_comb begin
    pair_data = '0;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      pair_data[OUT_W-1-(2*k)*TS_W   -: TS_W] = stored_q[ID_W+k*TS_W +: TS_W];
      pair_data[OUT_W-1-(2*k+1)*TS_W -: TS_W] = triad_data[ID_W+k*TS_W +: TS_W];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (triad_data_avl) state_d = S_CHECK;
      S_CHECK: begin
        if (!id_match)  state_d = S_STORE;
        else if (legal) state_d = S_PARSE;
        else            state_d = S_ACK;
      end
      S_STORE: state_d = S_ACK;
      S_PARSE: state_d = S_OUT;
      // The output register is raised on the first OUT cycle.
      // A transfer is possible only once that register shows valid.
      S_OUT:   if (avl_q && sensor_data_rdy) state_d = S_ACK;
      S_ACK:   if (!triad_data_avl) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      state_q      <= S_WAIT;
      stored_vld_q <= 1'b0;
      stale_cnt_q  <= '0;
      iter_q       <= '0;
      avl_q        <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      // The acknowledge is a registered output. It is high for every cycle spent in ACK.
      ack_q   <= (state_d == S_ACK);

      if (stored_vld_q) begin
        if (stale_fire) begin
          stored_vld_q <= 1'b0;
          stale_cnt_q  <= '0;
        end else if (stale_cnt_q != STALE_MAX) begin
          stale_cnt_q <= stale_cnt_q + CNT_W'(1);
        end
      end

      // State actions are placed after the expiry logic.
      // A STORE or PARSE in the same cycle therefore takes precedence.
      unique case (state_q)
        S_STORE: begin
          stored_vld_q <= 1'b1;
          stale_cnt_q  <= '0;
        end
        S_PARSE: begin
          iter_q       <= pair_data;
          stored_vld_q <= 1'b0;
          stale_cnt_q  <= '0;
        end
        S_OUT: begin
          if (!avl_q)               avl_q <= 1'b1;
          else if (sensor_data_rdy) avl_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stored frame is not reset.
  // stored_vld_q alone decides whether its contents mean anything.
  // Skipping the reset keeps the wide data register free of reset logic.
  always_ff @(posedge clk_72MHz) begin
    if (state_q == S_STORE) begin
      stored_q <= triad_data;
    end
  end

`ifdef PARSER_STATS_EN
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      stat_pairs   <= '0;
      stat_rejects <= '0;
      stat_stale   <= '0;
    end else begin
      if ((state_q == S_PARSE) && (stat_pairs != 16'hFFFF)) begin
        stat_pairs <= stat_pairs + 16'd1;
      end
      if ((state_q == S_CHECK) && id_match && !legal && (stat_rejects != 16'hFFFF)) begin
        stat_rejects <= stat_rejects + 16'd1;
      end
      if (stale_fire && (stat_stale != 16'hFFFF)) begin
        stat_stale <= stat_stale + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_parser_pairing.sv
// -----------------------------------------------------------------------------
// tb_data_parser_pairing
//
// Directed bench for data_parser_pairing.
// STALE_CYCLES is shortened to 200 so that the expiry scenarios stay short.
// Frames are offered with a hold-until-ack protocol.
// A monitor counts output transfers and acknowledge pulses.
// -----------------------------------------------------------------------------
module tb_data_parser_pairing;

  localparam int N      = 3;
  localparam int IDW    = 17;
  localparam int TSW    = 17;
  localparam int STALE  = 200;
  localparam int DW     = IDW + N * TSW;
  localparam int OW     = 2 * N * TSW;
  localparam int BUDGET = 300;

  logic          clk_72MHz = 1'b0;
  logic          reset;
  logic [DW-1:0] triad_data;
  logic          triad_data_avl;
  logic          reset_pulse_identifier;
  logic [OW-1:0] sensor_iterations;
  logic          sensor_data_avl;
  logic          sensor_data_rdy;
`ifdef PARSER_STATS_EN
  logic [15:0]   stat_pairs;
  logic [15:0]   stat_rejects;
  logic [15:0]   stat_stale;
`endif

  int n_vec = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  int ack_rises = 0;
  logic ack_prev = 1'b0;
  logic [OW-1:0] last_iter = '0;

  data_parser_pairing #(
    .NUM_SENSORS (N),
    .ID_W        (IDW),
    .TS_W        (TSW),
    .MIN_DIFF    (7500),
    .MAX_DIFF    (65535),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk_72MHz             (clk_72MHz),
    .reset                 (reset),
    .triad_data            (triad_data),
    .triad_data_avl        (triad_data_avl),
    .reset_pulse_identifier(reset_pulse_identifier),
    .sensor_iterations     (sensor_iterations),
    .sensor_data_avl       (sensor_data_avl),
    .sensor_data_rdy       (sensor_data_rdy)
`ifdef PARSER_STATS_EN
    ,
    .stat_pairs            (stat_pairs),
    .stat_rejects          (stat_rejects),
    .stat_stale            (stat_stale)
`endif
  );

  always #7 clk_72MHz = ~clk_72MHz;

  always @(posedge clk_72MHz) begin
    if (sensor_data_avl === 1'b1 && sensor_data_rdy === 1'b1) begin
      xfer_cnt  = xfer_cnt + 1;
      last_iter = sensor_iterations;
    end
    if (reset_pulse_identifier === 1'b1 && ack_prev !== 1'b1) ack_rises = ack_rises + 1;
    ack_prev <= reset_pulse_identifier;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] frame(input logic [16:0] id, input logic [16:0] t0,
                                          input logic [16:0] t1, input logic [16:0] t2);
    return {t2, t1, t0, id};
  endfunction

  function automatic logic [OW-1:0] pair(input logic [16:0] o0, input logic [16:0] n0,
                                         input logic [16:0] o1, input logic [16:0] n1,
                                         input logic [16:0] o2, input logic [16:0] n2);
    return {o0, n0, o1, n1, o2, n2};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    triad_data_avl = 1'b0;
    sensor_data_rdy = 1'b1;
    triad_data = '0;
    repeat (2) @(posedge clk_72MHz);
    #1;
    reset = 1'b0;
  endtask

  // Offer one frame and hold it until it is acknowledged.
  // gap:  idle cycles before the frame is raised.
  // hold: cycles for which ready stays low once the output is valid.
  task automatic send_frame(input string tag, input logic [DW-1:0] d, input bit exp_out,
                            input logic [OW-1:0] exp_it, input int gap, input int hold);
    int x0, a0, n, first, held;
    bit stable;
    logic [OW-1:0] snap;
    repeat (gap) @(posedge clk_72MHz);
    #1;
    x0 = xfer_cnt; a0 = ack_rises; first = -1; held = 0; stable = 1'b1; n = 0; snap = '0;
    triad_data = d;
    triad_data_avl = 1'b1;
    sensor_data_rdy = (hold == 0);
    while (reset_pulse_identifier !== 1'b1 && n < BUDGET) begin
      @(posedge clk_72MHz); #1; n++;
      if (sensor_data_avl === 1'b1) begin
        if (first < 0) begin
          first = n;
          snap = sensor_iterations;
        end else if (sensor_data_rdy == 1'b0 && sensor_iterations !== snap) begin
          stable = 1'b0;
        end
        if (sensor_data_rdy == 1'b0) begin
          held++;
          if (held >= hold) sensor_data_rdy = 1'b1;
        end
      end
    end
    check({tag, "_ack_seen"}, reset_pulse_identifier, 1'b1);
    check({tag, "_xfers"}, xfer_cnt - x0, exp_out ? 1 : 0);
    if (exp_out) begin
      check({tag, "_data"}, last_iter, exp_it);
      check({tag, "_latency"}, first, 4);
      if (hold > 0) begin
        check({tag, "_held_cycles"}, held, hold);
        check({tag, "_stable"}, stable, 1'b1);
      end
    end
    triad_data_avl = 1'b0;
    sensor_data_rdy = 1'b1;
    n = 0;
    while (reset_pulse_identifier !== 1'b0 && n < BUDGET) begin
      @(posedge clk_72MHz); #1; n++;
    end
    check({tag, "_ack_drop"}, reset_pulse_identifier, 1'b0);
    check({tag, "_ack_once"}, ack_rises - a0, 1);
  endtask

  initial begin
    int x0, n;
    reset = 1'b1;
    triad_data_avl = 1'b0;
    sensor_data_rdy = 1'b1;
    triad_data = '0;

    // Reset state
    do_reset();
    check("rst_avl", sensor_data_avl, 1'b0);
    check("rst_ack", reset_pulse_identifier, 1'b0);
    check("rst_iter", sensor_iterations, '0);

    // Basic pairing
    send_frame("t1a", frame(17'h1A2B, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t1b", frame(17'h1A2B, 9000, 10000, 11000), 1'b1,
               pair(1000, 9000, 2000, 10000, 3000, 11000), 0, 0);

    // A rejected second frame keeps the stored frame
    do_reset();
    send_frame("t2a", frame(17'h1A2B, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t2b", frame(17'h1A2B, 8000, 8000, 8000), 1'b0, '0, 0, 0);
    send_frame("t2c", frame(17'h1A2B, 9000, 10000, 11000), 1'b1,
               pair(1000, 9000, 2000, 10000, 3000, 11000), 0, 0);

    // MIN boundary: delta 7500 is rejected, 7501 is accepted
    do_reset();
    send_frame("min_a", frame(17'h0042, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("min_eq", frame(17'h0042, 8500, 9500, 10500), 1'b0, '0, 0, 0);
    send_frame("min_ok", frame(17'h0042, 8501, 9501, 10501), 1'b1,
               pair(1000, 8501, 2000, 9501, 3000, 10501), 0, 0);

    // MAX boundary: delta 65535 is rejected, 65534 is accepted
    do_reset();
    send_frame("max_a", frame(17'h0005, 1000, 1000, 1000), 1'b0, '0, 0, 0);
    send_frame("max_eq", frame(17'h0005, 66535, 9000, 9000), 1'b0, '0, 0, 0);
    send_frame("max_ok", frame(17'h0005, 66534, 9000, 9000), 1'b1,
               pair(1000, 66534, 1000, 9000, 1000, 9000), 0, 0);

    // Wrap-around: delta 7072 is rejected, 11072 is accepted
    do_reset();
    send_frame("t3a", frame(17'h0007, 130000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t3b", frame(17'h0007, 6000, 10000, 11000), 1'b0, '0, 0, 0);
    send_frame("t3c", frame(17'h0007, 10000, 10000, 11000), 1'b1,
               pair(130000, 10000, 2000, 10000, 3000, 11000), 0, 0);

    // A different id re-stores; an all-zero frame still pairs
    do_reset();
    send_frame("t4a", frame(17'h0001, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t4b", frame(17'h0002, 9000, 10000, 11000), 1'b0, '0, 0, 0);
    send_frame("t4c", frame(17'h0002, 17000, 18000, 19000), 1'b1,
               pair(9000, 17000, 10000, 18000, 11000, 19000), 0, 0);
    send_frame("t4z", frame(17'h0000, 0, 0, 0), 1'b0, '0, 0, 0);
    send_frame("t4zp", frame(17'h0000, 8000, 8000, 8000), 1'b1,
               pair(0, 8000, 0, 8000, 0, 8000), 0, 0);

    // Backpressure: ready stays low for 50 cycles
    do_reset();
    send_frame("t5a", frame(17'h0009, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t5b", frame(17'h0009, 9000, 10000, 11000), 1'b1,
               pair(1000, 9000, 2000, 10000, 3000, 11000), 0, 50);

    // Stale expiry: a gap of STALE drops the stored frame; a gap of STALE-10 keeps it
    do_reset();
    send_frame("t6a", frame(17'h0003, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    send_frame("t6stale", frame(17'h0003, 9000, 10000, 11000), 1'b0, '0, STALE, 0);
    send_frame("t6fresh", frame(17'h0003, 17000, 18000, 19000), 1'b1,
               pair(9000, 17000, 10000, 18000, 11000, 19000), STALE - 10, 0);

    // Reset while in OUT drops the pending pair
    do_reset();
    send_frame("t7a", frame(17'h0004, 1000, 2000, 3000), 1'b0, '0, 0, 0);
    x0 = xfer_cnt;
    triad_data = frame(17'h0004, 9000, 10000, 11000);
    sensor_data_rdy = 1'b0;
    triad_data_avl = 1'b1;
    n = 0;
    while (sensor_data_avl !== 1'b1 && n < BUDGET) begin
      @(posedge clk_72MHz); #1; n++;
    end
    check("t7_avl_up", sensor_data_avl, 1'b1);
    reset = 1'b1;
    @(posedge clk_72MHz); #1;
    check("t7_avl_after_rst", sensor_data_avl, 1'b0);
    check("t7_iter_after_rst", sensor_iterations, '0);
    check("t7_ack_after_rst", reset_pulse_identifier, 1'b0);
    reset = 1'b0;
    triad_data_avl = 1'b0;
    sensor_data_rdy = 1'b1;
    repeat (10) @(posedge clk_72MHz);
    #1;
    check("t7_no_xfer", xfer_cnt - x0, 0);
    check("t7_idle_avl", sensor_data_avl, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
